reg_file_mp_scoreboard: RTL

//  Parametrised successor to the single-write integer register file. Provides N read ports,
//  two write ports (WB0 = ALU writeback, WB1 = load writeback) and optional write-to-read bypass.

---
 rtl/rf_pkg.sv | 23 ++
 rtl/rf_scoreboard.sv | 61 ++++++
 rtl/reg_file_mp_scoreboard.sv | 115 +++++++++++
 3 files changed

// File: rtl/rf_pkg.sv
// Shared constants and helpers for the multi-port register file and its scoreboard.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package rf_pkg;

    // Writeback port indices; higher index wins a same-address collision.
    localparam int WB_ALU  = 0;
    localparam int WB_LOAD = 1;
    localparam int NUM_WB  = 2;

    // Upper bounds used by the read-port address array type.
    localparam int MAX_RD = 4;
    localparam int MAX_AW = 8;

    // Register index width for a given register count (at least one bit).
    function automatic int rf_aw(input int num_regs);
        return (num_regs > 1) ? $clog2(num_regs) : 1;
    endfunction

    // Read-port address array, one entry per read port.
    typedef logic [MAX_AW-1:0] rs_addr_arr_t [MAX_RD];

endpackage

// File: rtl/rf_scoreboard.sv
// Per-register busy scoreboard: set at issue, cleared at writeback, RAW lookup per read port.
// Latency: busy state updates on the clock edge; rs_busy lookup is combinational.
// Backpressure: none; the hazard report is advisory for the issue stage.
// Ports: clk/rst_n; issue_en/issue_rd set a bit; wb_live/wb_addr clear bits;
//        rs_addr/rs_fwd per read port -> rs_busy; busy_vec exposes the state.
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int NUM_REGS = 32,
    parameter int AW       = rf_aw(NUM_REGS),
    parameter int NUM_RD   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         issue_en,
    input  logic [AW-1:0]                issue_rd,
    input  logic [NUM_WB-1:0]            wb_live,
    input  logic [NUM_WB-1:0][AW-1:0]    wb_addr,
    input  logic [NUM_RD*AW-1:0]         rs_addr,
    input  logic [NUM_RD-1:0]            rs_fwd,
    output logic [NUM_RD-1:0]            rs_busy,
    output logic [NUM_REGS-1:0]          busy_vec
);

    logic [NUM_REGS-1:0] busy_q;
    logic [NUM_REGS-1:0] busy_d;

    // Clears are applied before the set so that a new producer issued in the
    // same cycle as an older producer's writeback keeps the register busy.
    always_comb begin
        busy_d = busy_q;
        for (int w = 0; w < NUM_WB; w++) begin
            if (wb_live[w]) begin
                busy_d[wb_addr[w]] = 1'b0;
            end
        end
        if (issue_en && (issue_rd != '0)) begin
            busy_d[issue_rd] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // A source being written this cycle is satisfied by the forwarded data.
    always_comb begin
        rs_busy = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            rs_busy[k] = busy_q[rs_addr[k*AW +: AW]] && !rs_fwd[k];
        end
    end

    assign busy_vec = busy_q;

endmodule

// File: rtl/reg_file_mp_scoreboard.sv
// Multi-read, dual-writeback integer register file with optional write bypass and busy scoreboard.
// Latency: reads combinational (0 cycles); writes and scoreboard commit on the rising edge.
// Backpressure: none; rs_busy flags RAW hazards for the issue stage to stall on.
// Ports: rs_addr/rs_data/rs_busy per read port; wb0_* ALU writeback; wb1_* load writeback;
//        issue_en/issue_rd mark a pending producer; wr_collide sticky dual-write flag; busy_vec debug.
module reg_file_mp_scoreboard
    import rf_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32,
    parameter int NUM_RD   = 2,
    parameter int BYPASS   = 1,
    localparam int AW      = rf_aw(NUM_REGS)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_RD*AW-1:0]     rs_addr,
    output logic [NUM_RD*XLEN-1:0]   rs_data,
    output logic [NUM_RD-1:0]        rs_busy,
    input  logic                     wb0_en,
    input  logic [AW-1:0]            wb0_addr,
    input  logic [XLEN-1:0]          wb0_data,
    input  logic                     wb1_en,
    input  logic [AW-1:0]            wb1_addr,
    input  logic [XLEN-1:0]          wb1_data,
    input  logic                     issue_en,
    input  logic [AW-1:0]            issue_rd,
    output logic                     wr_collide,
    output logic [NUM_REGS-1:0]      busy_vec
);

    // Writeback ports gathered into arrays, ordered by priority (last wins).
    logic [NUM_WB-1:0]           wb_live;
    logic [NUM_WB-1:0][AW-1:0]   wb_addr;
    logic [XLEN-1:0]             wb_data [NUM_WB];

    assign wb_addr[WB_ALU]  = wb0_addr;
    assign wb_addr[WB_LOAD] = wb1_addr;
    assign wb_data[WB_ALU]  = wb0_data;
    assign wb_data[WB_LOAD] = wb1_data;
    // Writes to x0 are dropped at the source so nothing downstream sees them.
    assign wb_live[WB_ALU]  = wb0_en && (wb0_addr != '0);
    assign wb_live[WB_LOAD] = wb1_en && (wb1_addr != '0);

    // Flop array rather than RAM: reset must clear every entry.
    logic [XLEN-1:0] regs [NUM_REGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_collide <= 1'b0;
        end else begin
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_live[w]) begin
                    regs[wb_addr[w]] <= wb_data[w];
                end
            end
            if (wb_live[WB_ALU] && wb_live[WB_LOAD] &&
                (wb_addr[WB_ALU] == wb_addr[WB_LOAD])) begin
                wr_collide <= 1'b1;
            end
        end
    end

    // Read muxes. rs_hit records that a same-cycle write targets the source,
    // independent of BYPASS, and feeds the scoreboard's hazard masking.
    logic [NUM_RD-1:0] rs_hit;
    logic [NUM_RD-1:0] rs_fwd;

    always_comb begin : rd_mux
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;
        rs_data = '0;
        rs_hit  = '0;
        for (int k = 0; k < NUM_RD; k++) begin
            ra = rs_addr[k*AW +: AW];
            rd = regs[ra];
            for (int w = 0; w < NUM_WB; w++) begin
                if (wb_live[w] && (wb_addr[w] == ra)) begin
                    rs_hit[k] = 1'b1;
                    if (BYPASS != 0) begin
                        rd = wb_data[w];
                    end
                end
            end
            // Bypassed data must not leak out while reset is held.
            if (!rst_n || (ra == '0)) begin
                rd = '0;
            end
            rs_data[k*XLEN +: XLEN] = rd;
        end
    end

    assign rs_fwd = (BYPASS != 0) ? rs_hit : '0;

    rf_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .AW       (AW),
        .NUM_RD   (NUM_RD)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .issue_en (issue_en),
        .issue_rd (issue_rd),
        .wb_live  (wb_live),
        .wb_addr  (wb_addr),
        .rs_addr  (rs_addr),
        .rs_fwd   (rs_fwd),
        .rs_busy  (rs_busy),
        .busy_vec (busy_vec)
    );

endmodule
